stg_idq: RTL and testbench
==========================

// Module: stg_idq
// PURPOSE
//  Parametrised decode-input queue between stg_if and stg_id. Buffers up to DEPTH {pc, instr, root_opc}
//  entries so IF keeps fetching while ID stalls. Uses valid/ready on both sides, a single-cycle flush and
//  an almost-full throttle. Empty or invalid slots present a NOP bubble to ID.
// PARAMETERS
//  DEPTH      4        entries; power of 2, >=2
//  PC_W       48       pc width (`HBIT_ADDR+1)
//  INSTR_W    24       instruction width (`HBIT_DATA+1)
//  OPC_W      8        root opcode width (`HBIT_OPC+1)
//  AFULL_LVL  DEPTH-1  occupancy at/above which ow_afull asserts; 1..DEPTH
// PORTS
//  iw_clk       in   1                    clock, rising edge
//  iw_rst       in   1                    asynchronous, active-low reset
//  iw_flush     in   1                    drop all entries (branch/exception redirect)
//  iw_valid     in   1                    IF presents an entry
//  ow_ready     out  1                    queue accepts the entry (= !full || iw_ready)
//  iw_pc        in   PC_W                 entry pc
//  iw_instr     in   INSTR_W              entry instruction
//  iw_root_opc  in   OPC_W                entry root opcode
//  ow_valid     out  1                    head entry valid toward ID
//  iw_ready     in   1                    ID consumes head (ID's !iw_stall)
//  ow_pc        out  PC_W                 head pc
//  ow_instr     out  INSTR_W              head instr; {`OPC_NOP,16'h0000} when !ow_valid
//  ow_root_opc  out  OPC_W                head root opcode; `OPC_NOP when !ow_valid
//  ow_count     out  $clog2(DEPTH)+1      occupancy 0..DEPTH
//  ow_afull     out  1                    ow_count >= AFULL_LVL
// BEHAVIOUR
//  - Reset (iw_rst=0, asynchronous): rd/wr pointers=0, count=0, ow_valid=0, ow_pc=0, ow_instr=NOP,
//    ow_root_opc=`OPC_NOP, ow_afull=0. Storage contents are don't-care.
//  - Push = iw_valid & ow_ready. Pop = ow_valid & iw_ready. Both evaluate at the same posedge.
//  - Head outputs come from registered storage (first-word-fall-through). An entry pushed at edge N is
//    visible on ow_* after edge N. Empty bypass is not supported; minimum latency is 1 cycle.
//  - Count: +1 on push only, -1 on pop only, unchanged on push and pop together.
//  - Full (count==DEPTH): ow_ready=iw_ready. A push and pop in the same cycle is legal and keeps the
//    queue full. A push attempted with ow_ready=0 is ignored; IF must hold its entry.
//  - Empty (count==0): ow_valid=0 and the outputs show the NOP bubble. iw_ready is ignored.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Full/empty are derived from count, never
//    from pointer equality.
//  - iw_flush=1 at an edge: pointers=0, count=0, ow_valid=0 (bubble) after that edge. A push or pop
//    in the same cycle is discarded, and flush wins over both. ow_ready stays combinational and is
//    unaffected by flush.
//  - ow_afull is registered from the next-state count, so it is valid in the same cycle as ow_count.
//  - While the head stalls (iw_ready=0), ow_pc, ow_instr and ow_root_opc hold stable.
//  - No X may propagate to ow_instr or ow_root_opc while ow_valid=0.
// TESTING
//  1 Reset: hold iw_rst=0 for 2 clocks -> ow_valid=0, ow_count=0, ow_root_opc=`OPC_NOP, ow_ready=1.
//  2 Single pass: push pc=48'h200, instr={`OPC_SRJCCso,`SR_IDX_PC,`CC_EQ,10'd3}, iw_ready=1 ->
//    1 clock later ow_valid=1, ow_pc=48'h200, instr matches; next clock ow_count=0.
//  3 Fill: DEPTH=4, iw_ready=0, push pc 0x100,0x101,0x102,0x103 -> ow_count=4, ow_ready=0,
//    ow_afull=1 from count 3; a 5th push is ignored; drain yields 0x100..0x103 in order.
//  4 Full simultaneous: count=4, push 0x104 with iw_ready=1 -> count stays 4, head becomes 0x101,
//    and 0x104 emerges last. Continue 8 cycles to exercise pointer wrap.
//  5 Flush: count=3 plus a push and pop in the same cycle as iw_flush=1 -> next cycle ow_count=0,
//    ow_valid=0, ow_instr={`OPC_NOP,16'h0000}; the next push pc=0x300 appears as the head.
//  6 Async reset mid-stream: drop iw_rst between edges with count=2 -> outputs reset immediately,
//    without waiting for a clock edge; after release, operation resumes from empty.

Source files
------------

// File: rtl/stg_idq.sv
// ---------------------------------------------------------------------------
// stg_idq - decode-input queue between the fetch (IF) and decode (ID) stages.
//
// This queue holds up to DEPTH {pc, instr, root_opc} entries, so IF can keep
// fetching while ID is stalled. The read side is first-word-fall-through from
// registered storage. An entry pushed at edge N appears on ow_* after edge N.
// There is no empty bypass. While the queue is empty, ID sees a NOP bubble.
//
// Ports
//   iw_clk       in   clock, rising edge
//   iw_rst       in   asynchronous active-low reset
//   iw_flush     in   drop every entry (branch / exception redirect)
//   iw_valid     in   IF presents an entry
//   ow_ready     out  queue accepts the entry (!full || iw_ready)
//   iw_pc        in   entry pc
//   iw_instr     in   entry instruction
//   iw_root_opc  in   entry root opcode
//   ow_valid     out  head entry valid toward ID
//   iw_ready     in   ID consumes the head
//   ow_pc        out  head pc (0 when !ow_valid)
//   ow_instr     out  head instruction ({OPC_NOP,16'h0} when !ow_valid)
//   ow_root_opc  out  head root opcode (OPC_NOP when !ow_valid)
//   ow_count     out  occupancy 0..DEPTH
//   ow_afull     out  registered ow_count >= AFULL_LVL
// ---------------------------------------------------------------------------
module stg_idq #(
    parameter int              DEPTH     = 4,
    parameter int              PC_W      = 48,
    parameter int              INSTR_W   = 24,
    parameter int              OPC_W     = 8,
    parameter int              AFULL_LVL = DEPTH - 1,
    parameter logic [OPC_W-1:0] OPC_NOP  = '0
) (
    input  logic                       iw_clk,
    input  logic                       iw_rst,
    input  logic                       iw_flush,
    input  logic                       iw_valid,
    output logic                       ow_ready,
    input  logic [PC_W-1:0]            iw_pc,
    input  logic [INSTR_W-1:0]         iw_instr,
    input  logic [OPC_W-1:0]           iw_root_opc,
    output logic                       ow_valid,
    input  logic                       iw_ready,
    output logic [PC_W-1:0]            ow_pc,
    output logic [INSTR_W-1:0]         ow_instr,
    output logic [OPC_W-1:0]           ow_root_opc,
    output logic [$clog2(DEPTH):0]     ow_count,
    output logic                       ow_afull
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [INSTR_W-1:0] INSTR_NOP = INSTR_W'({OPC_NOP, 16'h0000});

    logic [PC_W-1:0]    pc_mem    [DEPTH];
    logic [INSTR_W-1:0] instr_mem [DEPTH];
    logic [OPC_W-1:0]   opc_mem   [DEPTH];

    logic [PTR_W-1:0] rd_ptr, rd_ptr_nxt;
    logic [PTR_W-1:0] wr_ptr, wr_ptr_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             afull_q;
    logic             full, empty, push, pop;

    // Full and empty come only from the occupancy count. With wrapping
    // pointers, rd_ptr == wr_ptr can mean either full or empty.
    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // When the queue is full, an entry is accepted only if the head leaves
    // on the same edge. That write lands in the slot being vacated.
    assign ow_ready = !full || iw_ready;
    assign ow_valid = !empty;

    assign push = iw_valid && ow_ready;
    assign pop  = ow_valid && iw_ready;

    always_comb begin
        rd_ptr_nxt = rd_ptr;
        wr_ptr_nxt = wr_ptr;
        count_nxt  = count;
        if (iw_flush) begin
            rd_ptr_nxt = '0;
            wr_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (push) wr_ptr_nxt = wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr_nxt = rd_ptr + PTR_W'(1);
            if (push && !pop)      count_nxt = count + CNT_W'(1);
            else if (pop && !push) count_nxt = count - CNT_W'(1);
        end
    end

    always_ff @(posedge iw_clk or negedge iw_rst) begin
        if (!iw_rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count   <= '0;
            afull_q <= 1'b0;
        end else begin
            rd_ptr  <= rd_ptr_nxt;
            wr_ptr  <= wr_ptr_nxt;
            count   <= count_nxt;
            // Registered from the next count, so it changes in step with ow_count.
            afull_q <= (count_nxt >= CNT_W'(AFULL_LVL));
        end
    end

    // Storage has no reset because its contents are gated off while empty.
    always_ff @(posedge iw_clk) begin
        if (push && !iw_flush) begin
            pc_mem[wr_ptr]    <= iw_pc;
            instr_mem[wr_ptr] <= iw_instr;
            opc_mem[wr_ptr]   <= iw_root_opc;
        end
    end

    // Output muxing keeps uninitialised storage from reaching ID as X.
    assign ow_pc       = ow_valid ? pc_mem[rd_ptr]    : '0;
    assign ow_instr    = ow_valid ? instr_mem[rd_ptr] : INSTR_NOP;
    assign ow_root_opc = ow_valid ? opc_mem[rd_ptr]   : OPC_NOP;
    assign ow_count    = count;
    assign ow_afull    = afull_q;

endmodule

// File: tb/tb_stg_idq.sv
module tb_stg_idq;

    localparam int DEPTH     = 4;
    localparam int PC_W      = 48;
    localparam int INSTR_W   = 24;
    localparam int OPC_W     = 8;
    localparam int AFULL_LVL = 3;

    localparam logic [7:0]  OPC_NOP   = 8'h00;
    localparam logic [7:0]  OPC_SRJ   = 8'h5A;
    localparam logic [23:0] INSTR_NOP = {OPC_NOP, 16'h0000};
    localparam logic [23:0] INSTR_SRJ = {OPC_SRJ, 2'd3, 4'd1, 10'd3};

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [OPC_W-1:0]   opc;
    } ent_t;

    logic               iw_clk;
    logic               iw_rst;
    logic               iw_flush;
    logic               iw_valid;
    logic               ow_ready;
    logic [PC_W-1:0]    iw_pc;
    logic [INSTR_W-1:0] iw_instr;
    logic [OPC_W-1:0]   iw_root_opc;
    logic               ow_valid;
    logic               iw_ready;
    logic [PC_W-1:0]    ow_pc;
    logic [INSTR_W-1:0] ow_instr;
    logic [OPC_W-1:0]   ow_root_opc;
    logic [2:0]         ow_count;
    logic               ow_afull;

    stg_idq #(
        .DEPTH(DEPTH), .PC_W(PC_W), .INSTR_W(INSTR_W), .OPC_W(OPC_W),
        .AFULL_LVL(AFULL_LVL), .OPC_NOP(OPC_NOP)
    ) dut (
        .iw_clk(iw_clk), .iw_rst(iw_rst), .iw_flush(iw_flush),
        .iw_valid(iw_valid), .ow_ready(ow_ready), .iw_pc(iw_pc),
        .iw_instr(iw_instr), .iw_root_opc(iw_root_opc), .ow_valid(ow_valid),
        .iw_ready(iw_ready), .ow_pc(ow_pc), .ow_instr(ow_instr),
        .ow_root_opc(ow_root_opc), .ow_count(ow_count), .ow_afull(ow_afull)
    );

    initial begin
        iw_clk = 1'b0;
        forever #5 iw_clk = ~iw_clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1);
    end

    int   n_vec = 0;
    int   n_err = 0;
    ent_t q[$];
    logic exp_ready, act_ready;

    // Reference model: a plain FIFO of entries. It accepts while there is
    // room or while the head leaves. A flush empties it.
    task automatic drive_cycle(input logic v, input logic [PC_W-1:0] pc,
                               input logic [INSTR_W-1:0] ins, input logic [OPC_W-1:0] opc,
                               input logic rdy, input logic fl);
        logic do_push, do_pop;
        ent_t e;
        iw_valid = v; iw_pc = pc; iw_instr = ins; iw_root_opc = opc;
        iw_ready = rdy; iw_flush = fl;
        #1;
        exp_ready = (q.size() < DEPTH) || rdy;
        act_ready = ow_ready;
        do_push = v && exp_ready;
        do_pop  = (q.size() > 0) && rdy;
        e.pc = pc; e.instr = ins; e.opc = opc;
        @(posedge iw_clk);
        if (fl) begin
            q.delete();
        end else begin
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(e);
        end
        @(negedge iw_clk);
    endtask

    task automatic idle();
        iw_valid = 1'b0; iw_ready = 1'b0; iw_flush = 1'b0;
    endtask

    task automatic test_reset();
        iw_rst = 1'b0; iw_flush = 1'b0; iw_valid = 1'b0; iw_ready = 1'b0;
        iw_pc = '0; iw_instr = '0; iw_root_opc = '0;
        repeat (2) @(posedge iw_clk);
        @(negedge iw_clk);
        n_vec++; if (ow_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ow_valid); end
        n_vec++; if (ow_count !== 3'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", ow_count); end
        n_vec++; if (ow_root_opc !== OPC_NOP) begin n_err++; $display("FAIL reset_opc: got %h want %h", ow_root_opc, OPC_NOP); end
        n_vec++; if (ow_instr !== INSTR_NOP) begin n_err++; $display("FAIL reset_instr: got %h want %h", ow_instr, INSTR_NOP); end
        n_vec++; if (ow_pc !== 48'h0) begin n_err++; $display("FAIL reset_pc: got %h want 0", ow_pc); end
        n_vec++; if (ow_afull !== 1'b0) begin n_err++; $display("FAIL reset_afull: got %b want 0", ow_afull); end
        n_vec++; if (ow_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b want 1", ow_ready); end
        iw_rst = 1'b1;
        q.delete();
        @(negedge iw_clk);
    endtask

    task automatic test_single_pass();
        drive_cycle(1'b1, 48'h200, INSTR_SRJ, OPC_SRJ, 1'b1, 1'b0);
        n_vec++; if (ow_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b want 1", ow_valid); end
        n_vec++; if (ow_pc !== 48'h200) begin n_err++; $display("FAIL single_pc: got %h want 200", ow_pc); end
        n_vec++; if (ow_instr !== INSTR_SRJ) begin n_err++; $display("FAIL single_instr: got %h want %h", ow_instr, INSTR_SRJ); end
        n_vec++; if (ow_root_opc !== OPC_SRJ) begin n_err++; $display("FAIL single_opc: got %h want %h", ow_root_opc, OPC_SRJ); end
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        n_vec++; if (ow_count !== 3'd0) begin n_err++; $display("FAIL single_drain: got %0d want 0", ow_count); end
        n_vec++; if (ow_valid !== 1'b0) begin n_err++; $display("FAIL single_bubble: got %b want 0", ow_valid); end
        idle();
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(1'b1, 48'h100 + 48'(i), 24'($urandom()), 8'($urandom()), 1'b0, 1'b0);
            n_vec++; if (ow_count !== 3'(i + 1)) begin n_err++; $display("FAIL fill_count%0d: got %0d want %0d", i, ow_count, i + 1); end
            n_vec++; if (ow_afull !== ((i + 1) >= AFULL_LVL)) begin n_err++; $display("FAIL fill_afull%0d: got %b want %b", i, ow_afull, (i + 1) >= AFULL_LVL); end
            n_vec++; if (ow_pc !== 48'h100) begin n_err++; $display("FAIL fill_head%0d: got %h want 100", i, ow_pc); end
        end
        drive_cycle(1'b1, 48'h1FF, 24'h0, 8'h0, 1'b0, 1'b0);
        n_vec++; if (act_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %b want 0", act_ready); end
        n_vec++; if (ow_count !== 3'd4) begin n_err++; $display("FAIL full_ignore: got %0d want 4", ow_count); end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (ow_pc !== 48'h100 + 48'(i)) begin n_err++; $display("FAIL drain_pc%0d: got %h want %h", i, ow_pc, 48'h100 + 48'(i)); end
            n_vec++; if (ow_instr !== q[0].instr) begin n_err++; $display("FAIL drain_instr%0d: got %h want %h", i, ow_instr, q[0].instr); end
            drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        n_vec++; if (ow_valid !== 1'b0) begin n_err++; $display("FAIL drain_empty: got %b want 0", ow_valid); end
        idle();
    endtask

    task automatic test_full_simul();
        for (int i = 0; i < 4; i++)
            drive_cycle(1'b1, 48'h100 + 48'(i), 24'($urandom()), 8'($urandom()), 1'b0, 1'b0);
        drive_cycle(1'b1, 48'h104, 24'h123456, 8'h77, 1'b1, 1'b0);
        n_vec++; if (act_ready !== 1'b1) begin n_err++; $display("FAIL simul_ready: got %b want 1", act_ready); end
        n_vec++; if (ow_count !== 3'd4) begin n_err++; $display("FAIL simul_count: got %0d want 4", ow_count); end
        n_vec++; if (ow_pc !== 48'h101) begin n_err++; $display("FAIL simul_head: got %h want 101", ow_pc); end
        for (int i = 0; i < 8; i++) begin
            drive_cycle(1'b1, 48'h105 + 48'(i), 24'($urandom()), 8'($urandom()), 1'b1, 1'b0);
            n_vec++; if (ow_count !== 3'd4) begin n_err++; $display("FAIL wrap_count%0d: got %0d want 4", i, ow_count); end
            n_vec++; if (ow_pc !== 48'h102 + 48'(i)) begin n_err++; $display("FAIL wrap_head%0d: got %h want %h", i, ow_pc, 48'h102 + 48'(i)); end
        end
        for (int i = 0; i < 4; i++) begin
            n_vec++; if (ow_pc !== 48'h109 + 48'(i)) begin n_err++; $display("FAIL wrap_drain%0d: got %h want %h", i, ow_pc, 48'h109 + 48'(i)); end
            n_vec++; if (ow_root_opc !== q[0].opc) begin n_err++; $display("FAIL wrap_opc%0d: got %h want %h", i, ow_root_opc, q[0].opc); end
            drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        end
        idle();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++)
            drive_cycle(1'b1, 48'h2A0 + 48'(i), 24'($urandom()), 8'($urandom()), 1'b0, 1'b0);
        n_vec++; if (ow_count !== 3'd3) begin n_err++; $display("FAIL flush_pre: got %0d want 3", ow_count); end
        drive_cycle(1'b1, 48'h2FF, 24'hABCDEF, 8'h33, 1'b1, 1'b1);
        n_vec++; if (act_ready !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", act_ready); end
        n_vec++; if (ow_count !== 3'd0) begin n_err++; $display("FAIL flush_count: got %0d want 0", ow_count); end
        n_vec++; if (ow_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", ow_valid); end
        n_vec++; if (ow_instr !== INSTR_NOP) begin n_err++; $display("FAIL flush_instr: got %h want %h", ow_instr, INSTR_NOP); end
        n_vec++; if (ow_root_opc !== OPC_NOP) begin n_err++; $display("FAIL flush_opc: got %h want %h", ow_root_opc, OPC_NOP); end
        n_vec++; if (ow_afull !== 1'b0) begin n_err++; $display("FAIL flush_afull: got %b want 0", ow_afull); end
        drive_cycle(1'b1, 48'h300, 24'h0F0F0F, 8'h42, 1'b0, 1'b0);
        n_vec++; if (ow_pc !== 48'h300) begin n_err++; $display("FAIL flush_next: got %h want 300", ow_pc); end
        n_vec++; if (ow_count !== 3'd1) begin n_err++; $display("FAIL flush_next_count: got %0d want 1", ow_count); end
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_async_reset();
        drive_cycle(1'b1, 48'h3A0, 24'h111111, 8'h11, 1'b0, 1'b0);
        drive_cycle(1'b1, 48'h3A1, 24'h222222, 8'h22, 1'b0, 1'b0);
        idle();
        n_vec++; if (ow_count !== 3'd2) begin n_err++; $display("FAIL arst_pre: got %0d want 2", ow_count); end
        #2 iw_rst = 1'b0;
        #1;
        n_vec++; if (ow_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid: got %b want 0", ow_valid); end
        n_vec++; if (ow_count !== 3'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", ow_count); end
        n_vec++; if (ow_root_opc !== OPC_NOP) begin n_err++; $display("FAIL arst_opc: got %h want %h", ow_root_opc, OPC_NOP); end
        q.delete();
        @(negedge iw_clk);
        iw_rst = 1'b1;
        @(negedge iw_clk);
        drive_cycle(1'b1, 48'h400, 24'h444444, 8'h44, 1'b0, 1'b0);
        n_vec++; if (ow_pc !== 48'h400) begin n_err++; $display("FAIL arst_resume_pc: got %h want 400", ow_pc); end
        n_vec++; if (ow_count !== 3'd1) begin n_err++; $display("FAIL arst_resume_count: got %0d want 1", ow_count); end
        drive_cycle(1'b0, '0, '0, '0, 1'b1, 1'b0);
        idle();
    endtask

    task automatic test_random();
        ent_t h;
        for (int n = 0; n < 400; n++) begin
            if (q.size() > 0) h = q[0];
            else begin h.pc = '0; h.instr = INSTR_NOP; h.opc = OPC_NOP; end
            n_vec++; if (ow_valid !== (q.size() > 0)) begin n_err++; $display("FAIL rnd_valid@%0d: got %b want %b", n, ow_valid, q.size() > 0); end
            n_vec++; if (ow_pc !== h.pc) begin n_err++; $display("FAIL rnd_pc@%0d: got %h want %h", n, ow_pc, h.pc); end
            n_vec++; if (ow_instr !== h.instr) begin n_err++; $display("FAIL rnd_instr@%0d: got %h want %h", n, ow_instr, h.instr); end
            n_vec++; if (ow_root_opc !== h.opc) begin n_err++; $display("FAIL rnd_opc@%0d: got %h want %h", n, ow_root_opc, h.opc); end
            n_vec++; if (ow_count !== 3'(q.size())) begin n_err++; $display("FAIL rnd_count@%0d: got %0d want %0d", n, ow_count, q.size()); end
            n_vec++; if (ow_afull !== (q.size() >= AFULL_LVL)) begin n_err++; $display("FAIL rnd_afull@%0d: got %b want %b", n, ow_afull, q.size() >= AFULL_LVL); end
            drive_cycle($urandom_range(0, 3) != 0, {16'h0, 32'($urandom())}, 24'($urandom()),
                        8'($urandom()), $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
            n_vec++; if (act_ready !== exp_ready) begin n_err++; $display("FAIL rnd_ready@%0d: got %b want %b", n, act_ready, exp_ready); end
        end
        idle();
    endtask

    initial begin
        test_reset();
        test_single_pass();
        test_fill();
        test_full_simul();
        test_flush();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
